// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters (m0, m1).
// A round-robin arbiter picks one request while idle. A three-state sequencer
// (IDLE -> EXEC -> RESP) drives the ALU for one cycle and registers the result.
// The result goes back to the owning requester with a valid/ready handshake.
// Opcodes above MAX_OP are rejected without touching the ALU. They answer
// straight away with rsp_err=1.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   m0_req_valid/ready          m0 request handshake (ready only in IDLE)
//   m0_op, m0_src1, m0_src2     m0 opcode and operands
//   m1_*                        same for requester m1
//   rsp_valid[1:0]              one-hot: bit i = response for mi is valid
//   rsp_ready[1:0]              bit i = mi takes its response
//   rsp_data, rsp_overflow      registered ALU result / overflow
//   rsp_err                     1 = illegal opcode, op was not issued
//   busy                        1 whenever the sequencer is not idle
//   alu_enable, alu_op,
//   alu_src1, alu_src2          to the ALU (operands held outside EXEC)
//   alu_out, alu_overflow       from the ALU
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int              DATA_W = 32,
    parameter int              OP_W   = 5,
    parameter logic [OP_W-1:0] MAX_OP = 5'b10001
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic [OP_W-1:0]   m0_op,
    input  logic [DATA_W-1:0] m0_src1,
    input  logic [DATA_W-1:0] m0_src2,

    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic [OP_W-1:0]   m1_op,
    input  logic [DATA_W-1:0] m1_src1,
    input  logic [DATA_W-1:0] m1_src2,

    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_overflow,
    output logic              rsp_err,
    output logic              busy,

    output logic              alu_enable,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;
    logic              last_grant_reg, last_grant_next;
    logic [OP_W-1:0]   alu_op_reg, alu_op_next;
    logic [DATA_W-1:0] alu_src1_reg, alu_src1_next;
    logic [DATA_W-1:0] alu_src2_reg, alu_src2_next;
    logic [DATA_W-1:0] rsp_data_reg, rsp_data_next;
    logic              rsp_overflow_reg, rsp_overflow_next;
    logic              rsp_err_reg, rsp_err_next;

    // Requester inputs gathered into arrays so the grant can index them.
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [OP_W-1:0]   req_op   [2];
    logic [DATA_W-1:0] req_src1 [2];
    logic [DATA_W-1:0] req_src2 [2];

    assign req_valid   = {m1_req_valid, m0_req_valid};
    assign req_op[0]   = m0_op;
    assign req_op[1]   = m1_op;
    assign req_src1[0] = m0_src1;
    assign req_src1[1] = m1_src1;
    assign req_src2[0] = m0_src2;
    assign req_src2[1] = m1_src2;

    // Round robin: on a tie, the requester not served last wins.
    // A lone requester always wins.
    logic grant_any;
    logic grant_idx;
    logic can_accept;

    always_comb begin
        grant_any = |req_valid;
        if (&req_valid) begin
            grant_idx = ~last_grant_reg;
        end else begin
            grant_idx = req_valid[1];
        end
    end

    // Gating with rst_n keeps every output low while reset is held.
    assign can_accept = rst_n && (state_reg == ST_IDLE) && grant_any;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign req_ready[gi] = can_accept && (grant_idx == 1'(gi));
            assign rsp_valid[gi] = (state_reg == ST_RESP) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign m0_req_ready = req_ready[0];
    assign m1_req_ready = req_ready[1];

    // Next-state and register-update logic.
    always_comb begin
        state_next        = state_reg;
        owner_next        = owner_reg;
        last_grant_next   = last_grant_reg;
        alu_op_next       = alu_op_reg;
        alu_src1_next     = alu_src1_reg;
        alu_src2_next     = alu_src2_reg;
        rsp_data_next     = rsp_data_reg;
        rsp_overflow_next = rsp_overflow_reg;
        rsp_err_next      = rsp_err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (grant_any) begin
                    owner_next = grant_idx;
                    if (req_op[grant_idx] > MAX_OP) begin
                        // Rejected op: the ALU-facing registers stay put.
                        // The ALU never sees an op that is not issued.
                        state_next        = ST_RESP;
                        rsp_err_next      = 1'b1;
                        rsp_data_next     = '0;
                        rsp_overflow_next = 1'b0;
                    end else begin
                        state_next    = ST_EXEC;
                        alu_op_next   = req_op[grant_idx];
                        alu_src1_next = req_src1[grant_idx];
                        alu_src2_next = req_src2[grant_idx];
                    end
                end
            end
            ST_EXEC: begin
                rsp_data_next     = alu_out;
                rsp_overflow_next = alu_overflow;
                rsp_err_next      = 1'b0;
                state_next        = ST_RESP;
            end
            ST_RESP: begin
                // Only the owner's ready bit matters.
                if (rsp_ready[owner_reg]) begin
                    last_grant_next = owner_reg;
                    state_next      = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            owner_reg        <= 1'b0;
            last_grant_reg   <= 1'b1;
            alu_op_reg       <= '0;
            alu_src1_reg     <= '0;
            alu_src2_reg     <= '0;
            rsp_data_reg     <= '0;
            rsp_overflow_reg <= 1'b0;
            rsp_err_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            owner_reg        <= owner_next;
            last_grant_reg   <= last_grant_next;
            alu_op_reg       <= alu_op_next;
            alu_src1_reg     <= alu_src1_next;
            alu_src2_reg     <= alu_src2_next;
            rsp_data_reg     <= rsp_data_next;
            rsp_overflow_reg <= rsp_overflow_next;
            rsp_err_reg      <= rsp_err_next;
        end
    end

    assign busy         = (state_reg != ST_IDLE);
    assign alu_enable   = (state_reg == ST_EXEC);
    assign alu_op       = alu_op_reg;
    assign alu_src1     = alu_src1_reg;
    assign alu_src2     = alu_src2_reg;
    assign rsp_data     = rsp_data_reg;
    assign rsp_overflow = rsp_overflow_reg;
    assign rsp_err      = rsp_err_reg;

endmodule
